// File: rtl/mult_arbiter_pkg.sv
// Shared types and defaults for the shared shift-add multiplier arbiter.
// No logic; state encoding and counter sizing only.
// Backpressure: n/a.
package mult_arbiter_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must hold WIDTH-1 and still have headroom for the increment.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mult_core.sv
// Shift-add multiply datapath: start loads operands, each step consumes one multiplier bit.
// Latency: WIDTH step cycles after start; last flags the final step.
// Backpressure: none, it is sequenced entirely by the owner's FSM.
module mult_core
    import mult_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   acc,
    output logic                 last
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = cnt_w(WIDTH);

    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        if (start) begin
            acc_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, a};
            b_d     = b;
            cnt_d   = '0;
        end else if (step) begin
            if (b_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d = mcand_q << 1;
            b_d     = b_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            mcand_q <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign acc  = acc_q;
    assign last = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_arbiter.sv
// Arbitrates NREQ requesters onto one shift-add multiplier; MULT_ARB_RR_EN selects round-robin, else fixed priority.
// Latency: capture edge to rsp_valid is WIDTH+1 cycles; one operation every WIDTH+2 cycles.
// Backpressure: ack only in IDLE; requesters hold req and operands until they see their ack.
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     a_bus,
    input  logic [NREQ*WIDTH-1:0]     b_bus,
    output logic [NREQ-1:0]           ack,
    output logic                      busy,
    output logic                      rsp_valid,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [2*WIDTH-1:0]        p
);

    localparam int PW   = 2 * WIDTH;
    localparam int ID_W = $clog2(NREQ);

    state_t          state_q, state_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [PW-1:0]   p_q, p_d;
    logic            rsp_valid_q, rsp_valid_d;

    logic            win_vld;
    logic [ID_W-1:0] win_id;
    int              idx;
    logic [WIDTH-1:0] a_sel, b_sel;
    logic            core_start, core_step, core_last;
    logic [PW-1:0]   core_acc;

`ifdef MULT_ARB_RR_EN
    logic [ID_W-1:0] ptr_q, ptr_d;
`endif

    // First requesting index in search order wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef MULT_ARB_RR_EN
            idx = (int'(ptr_q) + k) % NREQ;
`else
            idx = k;
`endif
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
    end

    assign a_sel = a_bus[int'(win_id)*WIDTH +: WIDTH];
    assign b_sel = b_bus[int'(win_id)*WIDTH +: WIDTH];

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        rsp_id_d    = rsp_id_q;
        p_d         = p_q;
        rsp_valid_d = 1'b0;
        core_start  = 1'b0;
        core_step   = 1'b0;
        ack         = '0;
`ifdef MULT_ARB_RR_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    ack[win_id] = 1'b1;
                    core_start  = 1'b1;
                    id_d        = win_id;
                    state_d     = ST_MUL;
`ifdef MULT_ARB_RR_EN
                    ptr_d = (int'(win_id) == NREQ - 1) ? '0 : win_id + ID_W'(1);
`endif
                end
            end
            ST_MUL: begin
                core_step = 1'b1;
                if (core_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Result is registered on exit so p and rsp_id align with the rsp_valid pulse.
                p_d         = core_acc;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            id_q        <= '0;
            rsp_id_q    <= '0;
            p_q         <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            rsp_id_q    <= rsp_id_d;
            p_q         <= p_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

`ifdef MULT_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    mult_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (core_start),
        .step  (core_step),
        .a     (a_sel),
        .b     (b_sel),
        .acc   (core_acc),
        .last  (core_last)
    );

    assign busy      = (state_q != ST_IDLE) || rsp_valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign p         = p_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a cycle-level reference model checked every cycle.
module tb_mult_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int OPCYC = WIDTH + 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_bus;
    logic [NREQ*WIDTH-1:0] b_bus;
    logic [NREQ-1:0]       ack;
    logic                  busy;
    logic                  rsp_valid;
    logic [1:0]            rsp_id;
    logic [2*WIDTH-1:0]    p;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .ack       (ack),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .p         (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int start);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int oh2i(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) if (v[k]) return k;
        return -1;
    endfunction

    // Reference model: one operation at a time, next grant OPCYC cycles after the last,
    // response in the last of those cycles.
    bit have_cap = 0;
    int cap_cyc  = 0;
    int m_ptr    = 0;
    int pend_p   = 0;
    int pend_id  = 0;
    int last_p   = 0;
    int last_id  = 0;

    always @(negedge clk) begin
        int e_ack, e_busy, e_rv, w;
        if (!rst_n) begin
            check("rst_ack", int'(ack), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_rsp_valid", int'(rsp_valid), 0);
            check("rst_rsp_id", int'(rsp_id), 0);
            check("rst_p", int'(p), 0);
            have_cap = 0;
            m_ptr    = 0;
            last_p   = 0;
            last_id  = 0;
        end else begin
            e_rv   = (have_cap && cyc == cap_cyc + OPCYC) ? 1 : 0;
            e_busy = (have_cap && cyc >= cap_cyc + 1 && cyc <= cap_cyc + OPCYC) ? 1 : 0;
            if (e_rv != 0) begin
                last_p  = pend_p;
                last_id = pend_id;
            end
            e_ack = 0;
            if (!(have_cap && cyc < cap_cyc + OPCYC) && (|req)) begin
`ifdef MULT_ARB_RR_EN
                w = pick(req, m_ptr);
                m_ptr = (w + 1) % NREQ;
`else
                w = pick(req, 0);
`endif
                e_ack    = 1 << w;
                have_cap = 1;
                cap_cyc  = cyc;
                pend_id  = w;
                pend_p   = int'(a_bus[w*WIDTH +: WIDTH]) * int'(b_bus[w*WIDTH +: WIDTH]);
            end
            check("model_ack", int'(ack), e_ack);
            check("model_busy", int'(busy), e_busy);
            check("model_rsp_valid", int'(rsp_valid), e_rv);
            check("model_p", int'(p), last_p);
            check("model_rsp_id", int'(rsp_id), last_id);
        end
    end

    task automatic set_op(input int i, input int a, input int b);
        a_bus[i*WIDTH +: WIDTH] = WIDTH'(a);
        b_bus[i*WIDTH +: WIDTH] = WIDTH'(b);
    endtask

    task automatic wait_ack(output int c, output bit ok);
        ok = 0;
        c  = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (|ack) begin
                ok = 1;
                c  = cyc;
            end
        end
        if (!ok) check("ack_timeout", 0, 1);
    endtask

    task automatic wait_rsp(output int c, output bit ok);
        ok = 0;
        c  = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1;
                c  = cyc;
            end
        end
        if (!ok) check("rsp_timeout", 0, 1);
    endtask

    task automatic do_op(input int i, input int a, input int b, input int exp_p);
        int t0, c, rc;
        bit ok;
        @(posedge clk);
        #1;
        set_op(i, a, b);
        req    = '0;
        req[i] = 1'b1;
        t0     = cyc;
        wait_ack(c, ok);
        if (ok) begin
            check("op_ack_onehot", int'(ack), 1 << i);
            check("op_ack_same_cycle", c, t0);
        end
        @(posedge clk);
        #1;
        req = '0;
        wait_rsp(rc, ok);
        if (ok) begin
            check("op_p", int'(p), exp_p);
            check("op_rsp_id", int'(rsp_id), i);
            check("op_latency", rc - c - 1, WIDTH + 1);
        end
    endtask

    initial begin
        int c, c0, c1, prev, rc;
        bit ok;
        int exp_order [4];
`ifdef MULT_ARB_RR_EN
        exp_order = '{0, 1, 2, 3};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        rst_n = 1'b0;
        req   = '0;
        a_bus = '0;
        b_bus = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_p", int'(p), 0);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("idle_busy", int'(busy), 0);
        end

        // Contention: all four requesters held with 15*15.
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) set_op(i, 15, 15);
        req  = '1;
        prev = 0;
        for (int g = 0; g < 4; g++) begin
            wait_ack(c, ok);
            if (ok) begin
                check("cont_grant", oh2i(ack), exp_order[g]);
                if (g > 0) check("cont_spacing", c - prev, OPCYC);
                prev = c;
            end
            if (g == 3) begin
                @(posedge clk);
                #1;
                req = '0;
            end
        end
        wait_rsp(rc, ok);
        if (ok) check("cont_p", int'(p), 225);

        do_op(2, 13, 11, 143);
        do_op(1, 0, 9, 0);
        do_op(3, 1, 15, 15);

        // Reset while cnt==2: result must vanish.
        @(posedge clk);
        #1;
        set_op(0, 7, 5);
        req = 4'b0001;
        wait_ack(c, ok);
        @(posedge clk);
        #1;
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("midrst_rsp_valid", int'(rsp_valid), 0);
            check("midrst_p", int'(p), 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_op(2, 6, 7, 42);

        // Late request arriving while requester 0 is being multiplied.
        @(posedge clk);
        #1;
        set_op(0, 3, 5);
        req = 4'b0001;
        wait_ack(c0, ok);
        @(posedge clk);
        #1;
        req = '0;
        set_op(0, 15, 15);
        @(posedge clk);
        #1;
        set_op(1, 9, 9);
        req = 4'b0010;
        wait_ack(c1, ok);
        if (ok) begin
            check("late_ack_id", oh2i(ack), 1);
            check("late_ack_cycle", c1 - c0, OPCYC);
            check("late_first_p", int'(p), 15);
            check("late_first_id", int'(rsp_id), 0);
        end
        @(posedge clk);
        #1;
        req = '0;
        wait_rsp(rc, ok);
        if (ok) begin
            check("late_p", int'(p), 81);
            check("late_rsp_id", int'(rsp_id), 1);
        end

        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
